// File: rtl/infer_seq_ctrl_if.sv
// Handshake and memory/accumulator bundle for the inference sequencer.
//   start      : request one inference
//   busy, done : run in progress / one-cycle result strobe
//   digit      : recognised class index
//   addr       : shared read address to weight and pixel memories
//   mac_clr, mac_en, mac_last : accumulator strobes
//   score_sel  : accumulator select for the score scan
//   score_in   : signed score of the selected accumulator
// master = sequencer side, slave = datapath / host side.
interface infer_seq_ctrl_if #(
   parameter int ADDR_W     = 10,
   parameter int SCORE_BITS = 48
) ();
   logic                         start;
   logic                         busy;
   logic                         done;
   logic [3:0]                   digit;
   logic [ADDR_W-1:0]            addr;
   logic                         mac_clr;
   logic                         mac_en;
   logic                         mac_last;
   logic [3:0]                   score_sel;
   logic signed [SCORE_BITS-1:0] score_in;

   modport master (
      input  start, score_in,
      output busy, done, digit, addr, mac_clr, mac_en, mac_last, score_sel
   );

   modport slave (
      output start, score_in,
      input  busy, done, digit, addr, mac_clr, mac_en, mac_last, score_sel
   );
endinterface

// File: rtl/infer_seq_ctrl.sv
// Sequencer for the fully-connected output layer: sweeps the shared address
// across weight/pixel memories, strobes the parallel MAC accumulators in step
// with the memory read latency, then scans the accumulated scores and reports
// the argmax class.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : infer_seq_ctrl_if.master (start/busy/done/digit, addr,
//           mac_clr/mac_en/mac_last, score_sel/score_in)
// ADDR_W must satisfy 2**ADDR_W >= N_INPUTS; N_CLASSES must be <= 16.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, addr held at 0
// S_CLEAR | one-cycle mac_clr pulse
// S_FETCH | addr steps 0..N_INPUTS-1, one read issued per cycle
// S_DRAIN | MEM_LAT cycles for the last reads to reach the accumulators
// S_SCAN  | score_sel steps 0..N_CLASSES-1, running signed maximum
// S_DONE  | one-cycle done pulse, digit updated
module infer_seq_ctrl #(
   parameter int N_INPUTS   = 784,
   parameter int N_CLASSES  = 10,
   parameter int ADDR_W     = 10,
   parameter int SCORE_BITS = 48,
   parameter int MEM_LAT    = 1
) (
   input logic              clk,
   input logic              reset,
   infer_seq_ctrl_if.master bus
);
   localparam int                LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_INPUTS - 1);
   localparam logic [3:0]        SEL_LAST  = 4'(N_CLASSES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_DRAIN,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                       state;
   logic [LAT_W-1:0]             drain_cnt;
   logic [MEM_LAT-1:0]           vld_dl;
   logic [MEM_LAT-1:0]           last_dl;
   logic signed [SCORE_BITS-1:0] best;
   logic [3:0]                   best_idx;

   logic                         fetch_v;
   logic                         fetch_last;
   logic                         take;
   logic [3:0]                   idx_nxt;
   logic signed [SCORE_BITS-1:0] best_nxt;

   // First scanned score always seeds the maximum; afterwards only a strictly
   // greater score replaces it, so ties keep the lower class index.
   always_comb begin
      fetch_v    = (state == S_FETCH);
      fetch_last = fetch_v && (bus.addr == ADDR_LAST);
      take       = (bus.score_sel == 4'd0) || (bus.score_in > best);
      idx_nxt    = take ? bus.score_sel : best_idx;
      best_nxt   = take ? bus.score_in  : best;
   end

   // Read-valid delay line: a read issued in cycle c shows up as mac_en in
   // cycle c+MEM_LAT, together with its end-of-sweep flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_dl  <= '0;
         last_dl <= '0;
      end else begin
         vld_dl[0]  <= fetch_v;
         last_dl[0] <= fetch_last;
         for (int i = 1; i < MEM_LAT; i++) begin
            vld_dl[i]  <= vld_dl[i-1];
            last_dl[i] <= last_dl[i-1];
         end
      end
   end

   assign bus.mac_en   = vld_dl[MEM_LAT-1];
   assign bus.mac_last = last_dl[MEM_LAT-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.digit     <= 4'd0;
         bus.addr      <= '0;
         bus.mac_clr   <= 1'b0;
         bus.score_sel <= 4'd0;
         drain_cnt     <= '0;
         best          <= '0;
         best_idx      <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state       <= S_CLEAR;
                  bus.busy    <= 1'b1;
                  bus.mac_clr <= 1'b1;
               end
            end
            S_CLEAR: begin
               bus.mac_clr <= 1'b0;
               state       <= S_FETCH;
            end
            S_FETCH: begin
               if (fetch_last) begin
                  state     <= S_DRAIN;
                  bus.addr  <= '0;
                  drain_cnt <= LAT_W'(MEM_LAT - 1);
               end else begin
                  bus.addr <= bus.addr + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= S_SCAN;
               end else begin
                  drain_cnt <= drain_cnt - LAT_W'(1);
               end
            end
            S_SCAN: begin
               best     <= best_nxt;
               best_idx <= idx_nxt;
               if (bus.score_sel == SEL_LAST) begin
                  // Final comparison lands directly in digit so it is valid
                  // in the same cycle as done.
                  state         <= S_DONE;
                  bus.score_sel <= 4'd0;
                  bus.done      <= 1'b1;
                  bus.digit     <= idx_nxt;
               end else begin
                  bus.score_sel <= bus.score_sel + 4'd1;
               end
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
